// File: rtl/oam_dma_ctrl_if.sv
// CPU-bus and OAM-port signals shared by the sprite DMA controller and its surroundings.
// The master modport is the controller's view; the slave modport is the bus/OAM side.
interface oam_dma_ctrl_if #(
    parameter int OAM_WIDTH = 8
);
    logic [15:0]          cpu_addr;
    logic                 cpu_we;
    logic [7:0]           cpu_data;
    logic [OAM_WIDTH-1:0] oam_start;
    logic [7:0]           mem_data_in;
    logic                 cpu_halt;
    logic                 dma_active;
    logic [15:0]          mem_addr;
    logic                 mem_re;
    logic [OAM_WIDTH-1:0] oam_addr;
    logic                 oam_we;
    logic [7:0]           oam_data;

    modport master (
        input  cpu_addr, cpu_we, cpu_data, oam_start, mem_data_in,
        output cpu_halt, dma_active, mem_addr, mem_re, oam_addr, oam_we, oam_data
    );

    modport slave (
        output cpu_addr, cpu_we, cpu_data, oam_start, mem_data_in,
        input  cpu_halt, dma_active, mem_addr, mem_re, oam_addr, oam_we, oam_data
    );
endinterface

// File: rtl/oam_dma_ctrl.sv
// Sprite DMA sequencer: a CPU write of page P to DMA_REG halts the CPU and copies
// 2**OAM_WIDTH bytes from {P,00}.. into OAM, starting at the OAMADDR sampled on trigger.
module oam_dma_ctrl #(
    parameter int          OAM_WIDTH = 8,
    parameter logic [15:0] DMA_REG   = 16'h4014
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           clk_en,
    oam_dma_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE,
        HALT,
        ALIGN,
        READ,
        WRITE
    } state_t;

    localparam logic [OAM_WIDTH-1:0] LAST = '1;

    state_t               state;
    state_t               state_next;
    logic                 parity;
    logic [7:0]           page;
    logic [OAM_WIDTH-1:0] base;
    logic [OAM_WIDTH-1:0] count;
    logic [7:0]           data_q;
    logic                 trigger;

    assign trigger = bus.cpu_we && (bus.cpu_addr == DMA_REG);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else if (clk_en) begin
            state <= state_next;
        end
    end

    // Datapath: parity runs on every CPU cycle, transfer registers follow the FSM.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            parity <= 1'b0;
            page   <= '0;
            base   <= '0;
            count  <= '0;
            data_q <= '0;
        end else if (clk_en) begin
            parity <= ~parity;
            case (state)
                IDLE: begin
                    if (trigger) begin
                        page  <= bus.cpu_data;
                        base  <= bus.oam_start;
                        count <= '0;
                    end
                end
                READ:    data_q <= bus.mem_data_in;
                WRITE:   count  <= count + 1'b1;
                default: ;
            endcase
        end
    end

    // Triggers are only honoured from IDLE, so a write landing on the final WRITE is dropped.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (trigger) state_next = HALT;
            HALT:    state_next = parity ? ALIGN : READ;
            ALIGN:   state_next = READ;
            READ:    state_next = WRITE;
            WRITE:   state_next = (count == LAST) ? IDLE : READ;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        bus.cpu_halt   = 1'b0;
        bus.dma_active = 1'b0;
        bus.mem_re     = 1'b0;
        bus.mem_addr   = '0;
        bus.oam_we     = 1'b0;
        bus.oam_addr   = '0;
        case (state)
            HALT, ALIGN: begin
                bus.cpu_halt   = 1'b1;
                bus.dma_active = 1'b1;
            end
            READ: begin
                bus.cpu_halt   = 1'b1;
                bus.dma_active = 1'b1;
                bus.mem_re     = 1'b1;
                bus.mem_addr   = {page, 8'h00} + 16'(count);
            end
            WRITE: begin
                bus.cpu_halt   = 1'b1;
                bus.dma_active = 1'b1;
                bus.oam_we     = 1'b1;
                bus.oam_addr   = base + count;
            end
            default: ;
        endcase
    end

    assign bus.oam_data = data_q;
endmodule

// File: tb/tb_oam_dma_ctrl.sv
// Directed bench for oam_dma_ctrl: parity alignment, OAM wrap, clk_en gaps,
// re-trigger rejection, mid-transfer reset and non-DMA writes.
module tb_oam_dma_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic clk_en = 1'b0;
    logic pm = 1'b0;

    int checks = 0;
    int failures = 0;

    int halt_cnt, read_cnt, write_cnt;
    int order_err, addr_err, data_err, freeze_err;
    logic [7:0] first_oam, last_oam, zero_data;
    bit timed_out;

    oam_dma_ctrl_if bus ();

    oam_dma_ctrl dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .clk_en (clk_en),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    // Reference copy of the even/odd CPU-cycle parity.
    always @(posedge clk) begin
        if (!rst_n) pm <= 1'b0;
        else if (clk_en) pm <= ~pm;
    end

    function automatic logic [7:0] memByte(input logic [15:0] a);
        return a[7:0] ^ {a[11:8], a[15:12]} ^ 8'hA5;
    endfunction

    assign bus.mem_data_in = memByte(bus.mem_addr);

    function automatic logic [35:0] outs();
        return {bus.cpu_halt, bus.dma_active, bus.mem_addr, bus.mem_re,
                bus.oam_addr, bus.oam_we, bus.oam_data};
    endfunction

    task automatic checkOutput(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] addr, input logic we, input logic [7:0] data);
        bus.cpu_addr = addr;
        bus.cpu_we   = we;
        bus.cpu_data = data;
        clk_en       = 1'b1;
        @(posedge clk);
        #1;
        bus.cpu_we   = 1'b0;
        bus.cpu_addr = 16'h0000;
    endtask

    task automatic runTransfer(input logic [7:0] page, input logic [7:0] start, input bit halt_par,
                               input bit gaps, input int retrig_at, input int abort_at);
        bit done;
        bit en;
        bit snap_valid;
        logic [35:0] snap;
        int budget;
        halt_cnt = 0; read_cnt = 0; write_cnt = 0;
        order_err = 0; addr_err = 0; data_err = 0; freeze_err = 0;
        first_oam = 8'h55; last_oam = 8'h55; zero_data = 8'h00;
        done = 1'b0; snap_valid = 1'b0; budget = 0; snap = '0;
        bus.oam_start = start;
        // HALT runs with the parity opposite to the trigger cycle
        if (pm == halt_par) applyStimulus(16'h0000, 1'b0, 8'h00);
        applyStimulus(16'h4014, 1'b1, page);
        while (!done && budget < 3000) begin
            budget++;
            if (snap_valid && outs() !== snap) freeze_err++;
            snap_valid = 1'b0;
            if (!bus.cpu_halt) begin
                done = 1'b1;
            end else if (bus.mem_re && write_cnt == abort_at) begin
                rst_n  = 1'b0;
                clk_en = 1'b1;
                @(posedge clk);
                #1;
                checkOutput("abort_outs", 64'(outs()), 64'h0);
                rst_n = 1'b1;
                done  = 1'b1;
            end else begin
                en = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
                if (bus.oam_we && write_cnt == retrig_at) begin
                    en           = 1'b1;
                    bus.cpu_addr = 16'h4014;
                    bus.cpu_we   = 1'b1;
                    bus.cpu_data = 8'h05;
                end
                clk_en = en;
                if (en) begin
                    halt_cnt++;
                    if (bus.mem_re) begin
                        if (bus.mem_addr !== {page, read_cnt[7:0]}) order_err++;
                        read_cnt++;
                    end
                    if (bus.oam_we) begin
                        if (bus.oam_addr !== 8'(start + write_cnt[7:0])) addr_err++;
                        if (bus.oam_data !== memByte({page, write_cnt[7:0]})) data_err++;
                        if (write_cnt == 0) first_oam = bus.oam_addr;
                        if (bus.oam_addr == 8'h00) zero_data = bus.oam_data;
                        last_oam = bus.oam_addr;
                        write_cnt++;
                    end
                end else begin
                    snap       = outs();
                    snap_valid = 1'b1;
                end
                @(posedge clk);
                #1;
                bus.cpu_we   = 1'b0;
                bus.cpu_addr = 16'h0000;
            end
        end
        timed_out = !done;
        clk_en = 1'b1;
    endtask

    task automatic checkTransfer(input string tag, input int exp_halt);
        checkOutput({tag, "_timeout"}, 64'(timed_out), 64'h0);
        checkOutput({tag, "_halt_len"}, 64'(halt_cnt), 64'(exp_halt));
        checkOutput({tag, "_reads"}, 64'(read_cnt), 64'd256);
        checkOutput({tag, "_writes"}, 64'(write_cnt), 64'd256);
        checkOutput({tag, "_rd_order"}, 64'(order_err), 64'h0);
        checkOutput({tag, "_oam_addr"}, 64'(addr_err), 64'h0);
        checkOutput({tag, "_oam_data"}, 64'(data_err), 64'h0);
    endtask

    initial begin
        bus.cpu_addr  = 16'h0000;
        bus.cpu_we    = 1'b0;
        bus.cpu_data  = 8'h00;
        bus.oam_start = 8'h00;

        // Reset holds regardless of clk_en
        rst_n  = 1'b0;
        clk_en = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_cpu_halt", 64'(bus.cpu_halt), 64'h0);
        checkOutput("rst_dma_active", 64'(bus.dma_active), 64'h0);
        checkOutput("rst_mem_addr", 64'(bus.mem_addr), 64'h0);
        checkOutput("rst_mem_re", 64'(bus.mem_re), 64'h0);
        checkOutput("rst_oam_addr", 64'(bus.oam_addr), 64'h0);
        checkOutput("rst_oam_we", 64'(bus.oam_we), 64'h0);
        checkOutput("rst_oam_data", 64'(bus.oam_data), 64'h0);
        rst_n = 1'b1;

        // Even HALT: no alignment cycle
        runTransfer(8'h02, 8'h00, 1'b0, 1'b0, -1, -1);
        checkTransfer("even", 513);
        checkOutput("even_first_oam", 64'(first_oam), 64'h00);

        // Odd HALT, plus a trigger on the completing WRITE which must be dropped
        runTransfer(8'h02, 8'h00, 1'b1, 1'b0, 255, -1);
        checkTransfer("odd", 514);
        applyStimulus(16'h0000, 1'b0, 8'h00);
        checkOutput("odd_no_retrig", 64'(bus.cpu_halt), 64'h0);

        // OAM address wrap
        runTransfer(8'h03, 8'hF0, 1'b0, 1'b0, -1, -1);
        checkTransfer("wrap", 513);
        checkOutput("wrap_first_oam", 64'(first_oam), 64'hF0);
        checkOutput("wrap_last_oam", 64'(last_oam), 64'hEF);
        checkOutput("wrap_oam00_data", 64'(zero_data), 64'(memByte(16'h0310)));

        // clk_en gaps with a mid-transfer write of page 05
        runTransfer(8'h02, 8'h00, 1'b1, 1'b1, 50, -1);
        checkTransfer("gaps", 514);
        checkOutput("gaps_freeze", 64'(freeze_err), 64'h0);
        applyStimulus(16'h0000, 1'b0, 8'h00);
        checkOutput("gaps_idle_after", 64'(bus.dma_active), 64'h0);

        // Reset after 100 writes, then a fresh transfer from count 0
        runTransfer(8'h02, 8'h00, 1'b0, 1'b0, -1, 100);
        checkOutput("abort_writes", 64'(write_cnt), 64'd100);
        runTransfer(8'h04, 8'h00, 1'b0, 1'b0, -1, -1);
        checkTransfer("restart", 513);
        checkOutput("restart_first_oam", 64'(first_oam), 64'h00);

        // Writes to other registers never start a transfer
        applyStimulus(16'h4015, 1'b1, 8'h02);
        checkOutput("w4015_halt", 64'(bus.cpu_halt), 64'h0);
        checkOutput("w4015_active", 64'(bus.dma_active), 64'h0);
        applyStimulus(16'h2004, 1'b1, 8'h02);
        checkOutput("w2004_halt", 64'(bus.cpu_halt), 64'h0);
        applyStimulus(16'h0000, 1'b0, 8'h00);
        checkOutput("w2004_active", 64'(bus.dma_active), 64'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
